mux_oht: RTL and testbench



---
 rtl/mux_oht.sv | 123 ++++++++++++
 tb/tb_mux_oht.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux_oht.sv
// One-hot select data multiplexer with registered outputs.
// Flat AND-OR or recursive SPLIT-ary tree; both give identical results, multi-hot included.

module mux_oht_tree #(
    parameter type         DAT_T = logic [8-1:0],
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPLIT = 4
) (
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [WIDTH-1:0],
    output logic             vld,
    output DAT_T             dat
);

    if (WIDTH <= SPLIT) begin : g_flat
        // Masking with AND keeps an X on an unselected entry out of the result.
        always_comb begin
            dat = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                dat = DAT_T'(dat | (ary[i] & {$bits(DAT_T){oht[i]}}));
            end
            vld = |oht;
        end
    end else begin : g_tree
        localparam int unsigned GW = (WIDTH + SPLIT - 1) / SPLIT;
        localparam int unsigned NG = (WIDTH + GW - 1) / GW;

        logic [NG-1:0] g_vld;
        DAT_T          g_dat [NG-1:0];

        for (genvar g = 0; g < NG; g++) begin : g_grp
            localparam int unsigned LO  = g * GW;
            localparam int unsigned GWD = ((WIDTH - LO) < GW) ? (WIDTH - LO) : GW;

            DAT_T sub_ary [GWD-1:0];

            for (genvar j = 0; j < GWD; j++) begin : g_map
                assign sub_ary[j] = ary[LO + j];
            end

            mux_oht_tree #(
                .DAT_T (DAT_T),
                .WIDTH (GWD),
                .SPLIT (SPLIT)
            ) u_sub (
                .oht (oht[LO +: GWD]),
                .ary (sub_ary),
                .vld (g_vld[g]),
                .dat (g_dat[g])
            );
        end

        // Group results are already masked, so the parent only ORs them.
        always_comb begin
            dat = '0;
            for (int unsigned i = 0; i < NG; i++) begin
                dat = DAT_T'(dat | g_dat[i]);
            end
            vld = |g_vld;
        end
    end

endmodule

module mux_oht #(
    parameter type         DAT_T          = logic [8-1:0],
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned SPLIT          = 4,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [WIDTH-1:0],
    output logic             vld,
    output DAT_T             dat
);

    logic vld_n;
    DAT_T dat_n;

    if (WIDTH < 1 || SPLIT < 2) begin : g_bad_geom
        $error("mux_oht: WIDTH must be >= 1 and SPLIT >= 2");
    end

    if (IMPLEMENTATION == 0) begin : g_impl_flat
        // A radix equal to WIDTH collapses the tree to a single flat level.
        mux_oht_tree #(
            .DAT_T (DAT_T),
            .WIDTH (WIDTH),
            .SPLIT (WIDTH)
        ) u_core (
            .oht (oht),
            .ary (ary),
            .vld (vld_n),
            .dat (dat_n)
        );
    end else if (IMPLEMENTATION == 1) begin : g_impl_tree
        mux_oht_tree #(
            .DAT_T (DAT_T),
            .WIDTH (WIDTH),
            .SPLIT (SPLIT)
        ) u_core (
            .oht (oht),
            .ary (ary),
            .vld (vld_n),
            .dat (dat_n)
        );
    end else begin : g_impl_bad
        $error("mux_oht: IMPLEMENTATION must be 0 or 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            vld <= vld_n;
            dat <= dat_n;
        end
    end

endmodule

// File: tb/tb_mux_oht.sv
// Directed and random checks of mux_oht across flat, tree and non-power-of-split geometries.

module tb_mux_oht;

    logic        clk;
    logic        rst;
    logic [15:0] oht16;
    logic [7:0]  ary16 [15:0];
    logic [12:0] oht13;
    logic [7:0]  ary13 [12:0];

    logic       vld_f,  vld_t,  vld_t2, vld_13;
    logic [7:0] dat_f,  dat_t,  dat_t2, dat_13;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) u_flat (
        .clk(clk), .rst(rst), .oht(oht16), .ary(ary16), .vld(vld_f), .dat(dat_f));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1)) u_tree (
        .clk(clk), .rst(rst), .oht(oht16), .ary(ary16), .vld(vld_t), .dat(dat_t));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(2), .IMPLEMENTATION(1)) u_tree2 (
        .clk(clk), .rst(rst), .oht(oht16), .ary(ary16), .vld(vld_t2), .dat(dat_t2));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(13), .SPLIT(4), .IMPLEMENTATION(1)) u_w13 (
        .clk(clk), .rst(rst), .oht(oht13), .ary(ary13), .vld(vld_13), .dat(dat_13));

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed vld/dat=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [8:0] exp);
        chk({tag, "/flat"},   {vld_f,  dat_f},  exp);
        chk({tag, "/tree4"},  {vld_t,  dat_t},  exp);
        chk({tag, "/tree2"},  {vld_t2, dat_t2}, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref16();
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 16; i++) if (oht16[i]) d = d | ary16[i];
        return {|oht16, d};
    endfunction

    function automatic logic [8:0] ref13();
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 13; i++) if (oht13[i]) d = d | ary13[i];
        return {|oht13, d};
    endfunction

    initial begin
        rst   = 1'b1;
        oht16 = 16'h0000;
        oht13 = 13'h0000;
        for (int i = 0; i < 16; i++) ary16[i] = 8'(i);
        for (int i = 0; i < 13; i++) ary13[i] = 8'(i + 100);
        #2;
        chk16("reset_initial", 9'h000);
        chk("reset_initial/w13", {vld_13, dat_13}, 9'h000);
        step();
        rst = 1'b0;

        // Idle
        step();
        chk16("idle", 9'h000);

        // One-hot sweep, one new vector every cycle
        for (int i = 0; i < 16; i++) begin
            oht16 = 16'h0001 << i;
            step();
            chk16($sformatf("sweep%0d", i), {1'b1, 8'(i)});
        end

        // Async reset mid-run, checked before any clock edge
        oht16 = 16'h0008;
        step();
        chk16("pre_reset", 9'h103);
        #2;
        rst = 1'b1;
        #1;
        chk16("reset_async", 9'h000);
        step();
        chk16("reset_held", 9'h000);
        rst = 1'b0;
        step();
        chk16("reset_release", 9'h103);

        // Multi-hot
        ary16[1] = 8'h0F;
        ary16[2] = 8'hF0;
        oht16    = 16'h0006;
        step();
        chk16("multihot", 9'h1FF);

        // X on unselected entries must stay masked
        ary16[0]  = 8'hxx;
        ary16[15] = 8'hxx;
        oht16     = 16'h0004;
        step();
        chk16("xmask", 9'h1F0);
        oht16 = 16'h0000;
        step();
        chk16("xmask_idle", 9'h000);

        // WIDTH=13 geometry
        for (int i = 0; i < 13; i++) begin
            oht13 = 13'h0001 << i;
            step();
            chk($sformatf("w13_sweep%0d", i), {vld_13, dat_13}, {1'b1, 8'(i + 100)});
        end
        oht13 = 13'h0000;
        step();
        chk("w13_idle", {vld_13, dat_13}, 9'h000);

        // Random regression against the OR reference
        for (int c = 0; c < 10000; c++) begin
            logic [8:0] e16, e13;
            for (int i = 0; i < 16; i++) ary16[i] = 8'($urandom);
            for (int i = 0; i < 13; i++) ary13[i] = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    oht16 = 16'h0000;
                    oht13 = 13'h0000;
                end
                1: begin
                    oht16 = 16'h0001 << $urandom_range(0, 15);
                    oht13 = 13'h0001 << $urandom_range(0, 12);
                end
                default: begin
                    oht16 = 16'($urandom);
                    oht13 = 13'($urandom);
                end
            endcase
            e16 = ref16();
            e13 = ref13();
            step();
            chk16("rand", e16);
            chk("rand/w13", {vld_13, dat_13}, e13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
